// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the datapath.
// The controller is the master: it receives opcode/handshakes and drives every control strobe.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic       mem_ready;
  logic       trap_ack;
  logic       branch;
  logic       pc_update;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] res_src;
  logic [1:0] mocsr;
  logic       illegal;
  logic       timeout;
  logic [3:0] state;

  modport master (
    input  op, mem_ready, trap_ack,
    output branch, pc_update, ir_write, reg_write, mem_write, adr_src,
           alu_src_a, alu_src_b, alu_op, res_src, mocsr, illegal, timeout, state
  );

  modport slave (
    output op, mem_ready, trap_ack,
    input  branch, pc_update, ir_write, reg_write, mem_write, adr_src,
           alu_src_a, alu_src_b, alu_op, res_src, mocsr, illegal, timeout, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I main control FSM with memory-wait watchdog and trap state.
// All control outputs are Moore functions of the state (FETCH strobes also follow ready).
module multicycle_ctrl #(
  parameter bit          EN_CSR   = 1'b1,
  parameter bit          MEM_WAIT = 1'b1,
  parameter int unsigned MAX_WAIT = 15
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    CSR      = 4'd11,
    TRAP     = 4'd12
  } stateT;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  stateT      stateReg;
  stateT      stateNext;
  logic [7:0] waitCnt;
  logic       illegalReg;
  logic       timeoutReg;
  logic       ready;
  logic       waitState;
  logic       stalled;
  logic       watchdogFire;
  logic       setIllegal;

  assign ready        = MEM_WAIT ? bus.mem_ready : 1'b1;
  assign waitState    = (stateReg == FETCH) || (stateReg == MEMREAD) || (stateReg == MEMWRITE);
  assign stalled      = waitState && !ready;
  assign watchdogFire = stalled && (waitCnt == MAX_WAIT_C);

  always_ff @(posedge clk) begin
    if (reset) stateReg <= FETCH;
    else       stateReg <= stateNext;
  end

  // The watchdog only counts consecutive stall cycles within one visit to a memory state.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCnt    <= 8'd0;
      illegalReg <= 1'b0;
      timeoutReg <= 1'b0;
    end else begin
      if (stateNext != stateReg) waitCnt <= 8'd0;
      else if (stalled)          waitCnt <= waitCnt + 8'd1;
      if (stateReg == TRAP && bus.trap_ack) begin
        illegalReg <= 1'b0;
        timeoutReg <= 1'b0;
      end else begin
        if (setIllegal)   illegalReg <= 1'b1;
        if (watchdogFire) timeoutReg <= 1'b1;
      end
    end
  end

  always_comb begin
    stateNext  = FETCH;
    setIllegal = 1'b0;
    case (stateReg)
      FETCH:    stateNext = ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          7'd3, 7'd35: stateNext = MEMADR;
          7'd51:       stateNext = EXECR;
          7'd19:       stateNext = EXECI;
          7'd111:      stateNext = JAL;
          7'd99:       stateNext = BEQ;
          7'd115: begin
            if (EN_CSR) stateNext = CSR;
            else begin
              stateNext  = TRAP;
              setIllegal = 1'b1;
            end
          end
          default: begin
            stateNext  = TRAP;
            setIllegal = 1'b1;
          end
        endcase
      end
      MEMADR:   stateNext = (bus.op == 7'd3) ? MEMREAD : MEMWRITE;
      MEMREAD:  stateNext = ready ? MEMWB : MEMREAD;
      MEMWB:    stateNext = FETCH;
      MEMWRITE: stateNext = ready ? FETCH : MEMWRITE;
      EXECR:    stateNext = ALUWB;
      EXECI:    stateNext = ALUWB;
      ALUWB:    stateNext = FETCH;
      JAL:      stateNext = ALUWB;
      BEQ:      stateNext = FETCH;
      CSR:      stateNext = FETCH;
      TRAP:     stateNext = bus.trap_ack ? FETCH : TRAP;
      default:  stateNext = FETCH;
    endcase
    // A completing access in the same cycle beats the watchdog; watchdogFire already requires !ready.
    if (watchdogFire) stateNext = TRAP;
  end

  always_comb begin
    bus.branch    = 1'b0;
    bus.pc_update = 1'b0;
    bus.ir_write  = 1'b0;
    bus.reg_write = 1'b0;
    bus.mem_write = 1'b0;
    bus.adr_src   = 1'b0;
    bus.alu_src_a = 2'b00;
    bus.alu_src_b = 2'b00;
    bus.alu_op    = 2'b00;
    bus.res_src   = 2'b00;
    bus.mocsr     = 2'b00;
    bus.illegal   = illegalReg;
    bus.timeout   = timeoutReg;
    bus.state     = stateReg;
    case (stateReg)
      FETCH: begin
        bus.alu_src_b = 2'b10;
        bus.res_src   = 2'b10;
        bus.ir_write  = ready;
        bus.pc_update = ready;
      end
      DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
      end
      MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      MEMREAD:  bus.adr_src = 1'b1;
      MEMWB: begin
        bus.res_src   = 2'b01;
        bus.reg_write = 1'b1;
      end
      MEMWRITE: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
      end
      EXECR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b10;
      end
      EXECI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 2'b10;
      end
      ALUWB:    bus.reg_write = 1'b1;
      JAL: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_update = 1'b1;
      end
      BEQ: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b01;
        bus.branch    = 1'b1;
      end
      CSR: begin
        bus.res_src   = 2'b01;
        bus.reg_write = 1'b1;
        bus.mocsr     = 2'b01;
      end
      default: ;
    endcase
  end

endmodule
